// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_pipe datapath ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response channel between the operand-read stage and writeback.
interface alu_pipe_if #(parameter int WIDTH = 16);
    import alu_pkg::*;

    // Both channels are valid/ready: a transfer happens on the rising edge where
    // valid && ready; valid and its payload must hold steady until that edge.
    logic             in_valid;
    logic             in_ready;
    alu_op_t          opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, opcode, operand1, operand2, out_ready,
        input  in_ready, result, flags, out_valid
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2, out_ready,
        output in_ready, result, flags, out_valid
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier; the start edge performs the first of
// WIDTH iterations. Instantiated by alu_pipe only when ALU_MUL_EN is defined.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q    <= mplier_i[0] ? {{WIDTH{1'b0}}, mcand_i} : '0;
                mcand_q  <= {{WIDTH{1'b0}}, mcand_i} << 1;
                mplier_q <= mplier_i >> 1;
                cnt_q    <= CW'(1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                // done pulses for one cycle once the final partial product is added
                if (cnt_q == LAST_CNT) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked integer ALU with NZCV flags. Define ALU_MUL_EN to enable the
// iterative multiplier for ALU_MUL; otherwise ALU_MUL returns 0 in one cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus,
    output state_t     state_o
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] op1, op2;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_ext, shl_ext, shr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             accept;

    assign op1    = bus.operand1;
    assign op2    = bus.operand2;
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        shamt   = op1[SW-1:0];
        add_ext = {1'b0, op2} + {1'b0, op1};
        // Widened shifts leave the last bit shifted out in the extra position
        shl_ext = {1'b0, op2} << shamt;
        shr_ext = {op2, 1'b0} >> shamt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.opcode)
            ALU_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (op2[WIDTH-1] == op1[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != op2[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = op2 - op1;
                alu_c   = (op2 < op1);
                alu_v   = (op2[WIDTH-1] != op1[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != op2[WIDTH-1]);
            end
            ALU_AND: alu_res = op2 & op1;
            ALU_OR:  alu_res = op2 | op1;
            ALU_XOR: alu_res = op2 ^ op1;
            ALU_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            ALU_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_hi_nz;

    assign mul_start = accept && (bus.opcode == ALU_MUL);
    assign mul_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .mcand_i   (op2),
        .mplier_i  (op1),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef ALU_MUL_EN
                        if (bus.opcode == ALU_MUL) begin
                            state_q <= BUSY;
                        end else begin
                            result_q    <= alu_res;
                            flags_q     <= pack_flags(alu_res[WIDTH-1], alu_res == '0,
                                                      alu_c, alu_v);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
`else
                        result_q    <= alu_res;
                        flags_q     <= pack_flags(alu_res[WIDTH-1], alu_res == '0,
                                                  alu_c, alu_v);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end
                BUSY: begin
`ifdef ALU_MUL_EN
                    if (mul_done) begin
                        result_q    <= mul_prod[WIDTH-1:0];
                        flags_q     <= pack_flags(mul_prod[WIDTH-1],
                                                  mul_prod[WIDTH-1:0] == '0,
                                                  mul_hi_nz, mul_hi_nz);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (!mul_busy) begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe; expectations follow ALU_MUL_EN if defined.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int EW    = WIDTH + 4;

`ifdef ALU_MUL_EN
    localparam int          MUL_LAT  = WIDTH + 1;
    localparam logic [15:0] MUL1_RES = 16'h0000;
    localparam logic [3:0]  MUL1_FLG = 4'b0111;
    localparam logic [15:0] MUL2_RES = 16'h000F;
    localparam logic [3:0]  MUL2_FLG = 4'b0000;
`else
    localparam int          MUL_LAT  = 1;
    localparam logic [15:0] MUL1_RES = 16'h0000;
    localparam logic [3:0]  MUL1_FLG = 4'b0100;
    localparam logic [15:0] MUL2_RES = 16'h0000;
    localparam logic [3:0]  MUL2_FLG = 4'b0100;
`endif

    logic   clk = 1'b0;
    logic   rst;
    state_t state;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [EW-1:0] exp_q[$];

    alu_pipe_if #(.WIDTH(WIDTH)) bus();

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic send(input alu_op_t op, input logic [15:0] a1, input logic [15:0] a2);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.operand1 = a1;
        bus.operand2 = a2;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n + 1;
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_state"}, 32'(state), 32'(IDLE));
    endtask

    task automatic run_op(input string tag, input alu_op_t op, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] er,
                          input logic [3:0] ef, input int elat);
        int lat;
        logic [EW-1:0] e;
        exp_q.push_back({ef, er});
        send(op, a1, a2);
        wait_out(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(elat));
        e = exp_q.pop_front();
        check_val({tag, "_res"}, 32'(bus.result), 32'(e[15:0]));
        check_val({tag, "_flags"}, 32'(bus.flags), 32'(e[19:16]));
        release_out(tag);
    endtask

    initial begin
        int late_ov;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = ALU_ADD;
        bus.operand1  = '0;
        bus.operand2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ov", 32'(bus.out_valid), 32'd0);
        check_val("rst_res", 32'(bus.result), 32'd0);
        check_val("rst_flags", 32'(bus.flags), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_state", 32'(state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // arithmetic / logic / shift vectors (operand1, operand2 order)
        run_op("add_ovf",  ALU_ADD, 16'h0001, 16'h7FFF, 16'h8000, 4'b1001, 1);
        run_op("add_cry",  ALU_ADD, 16'h0001, 16'hFFFF, 16'h0000, 4'b0110, 1);
        run_op("sub_brw",  ALU_SUB, 16'h0005, 16'h0003, 16'hFFFE, 4'b1010, 1);
        run_op("sub_ovf",  ALU_SUB, 16'h0001, 16'h8000, 16'h7FFF, 4'b0001, 1);
        run_op("and",      ALU_AND, 16'hFF00, 16'hF0F0, 16'hF000, 4'b1000, 1);
        run_op("or",       ALU_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1);
        run_op("xor_zero", ALU_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1);
        run_op("shl_c",    ALU_SHL, 16'h0001, 16'h8001, 16'h0002, 4'b0010, 1);
        run_op("shl_0",    ALU_SHL, 16'h0000, 16'h1234, 16'h1234, 4'b0000, 1);
        run_op("shr_0",    ALU_SHR, 16'h0000, 16'h0001, 16'h0001, 4'b0000, 1);
        run_op("shr_4",    ALU_SHR, 16'h0004, 16'h00F8, 16'h000F, 4'b0010, 1);
        run_op("mul_hi",   ALU_MUL, 16'h0100, 16'h0100, MUL1_RES, MUL1_FLG, MUL_LAT);
        run_op("mul_sml",  ALU_MUL, 16'h0005, 16'h0003, MUL2_RES, MUL2_FLG, MUL_LAT);

        // backpressure: result held, new requests ignored while result pending
        begin
            int lat;
            send(ALU_ADD, 16'h1111, 16'h1234);
            wait_out(lat);
            check_val("bp_lat", 32'(lat), 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.opcode   = ALU_SUB;
                bus.operand1 = 16'h0F0F;
                bus.operand2 = 16'h0001;
                @(posedge clk);
                #1;
                check_val("bp_res", 32'(bus.result), 32'h2345);
                check_val("bp_flags", 32'(bus.flags), 32'h0);
                check_val("bp_ov", 32'(bus.out_valid), 32'd1);
                check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            release_out("bp");
            late_ov = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) late_ov++;
            end
            check_val("bp_no_ghost", 32'(late_ov), 32'd0);
        end

        // reset in the middle of a multiply
        send(ALU_MUL, 16'h0003, 16'h0007);
        repeat (7) @(posedge clk);
`ifdef ALU_MUL_EN
        #1;
        check_val("mid_mul_state", 32'(state), 32'(BUSY));
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mrst_ov", 32'(bus.out_valid), 32'd0);
        check_val("mrst_res", 32'(bus.result), 32'd0);
        check_val("mrst_flags", 32'(bus.flags), 32'd0);
        check_val("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        late_ov = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) late_ov++;
        end
        check_val("mrst_no_late_ov", 32'(late_ov), 32'd0);
        check_val("mrst_state", 32'(state), 32'(IDLE));

        // unit still works after the abort
        run_op("post_rst_add", ALU_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked integer ALU for the CPU datapath. Accepts one operation per transaction over a valid/ready input channel, computes it in a single registered cycle or an iterative multi-cycle multiply, and holds the result plus NZCV flags on a valid/ready output channel until the consumer takes it. Replaces the fixed 16-bit add/sub unit between the register-file read stage and writeback.

## Interface
- WIDTH, 16, operand/result width in bits; minimum 4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE with rst low.
- opcode  in  3  operation select (alu_pkg::alu_op_t).
- operand1  in  WIDTH  first operand; shift amount for shifts.
- operand2  in  WIDTH  second operand.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.

## Operation
- Opcodes: 0 ADD op2+op1; 1 SUB op2−op1; 2 AND; 3 OR; 4 XOR; 5 SHL op2<<op1[$clog2(WIDTH)-1:0]; 6 SHR (logical), same amount; 7 MUL (low WIDTH bits of unsigned op2*op1).
- Accept on the clk edge where in_valid && in_ready; opcode/operands captured at that edge; inputs ignored otherwise.
- FSM: IDLE --accept non-MUL--> DONE; IDLE --accept MUL--> BUSY; BUSY --iteration count = WIDTH--> DONE; DONE --out_ready--> IDLE.
- Flags: Z = (result==0); N = result[WIDTH-1].
- ADD: C = carry out, V = signed overflow. SUB: C = borrow (op2 < op1 unsigned), V = signed overflow.
- AND/OR/XOR: C=V=0. Shifts: C = last bit shifted out, 0 for amount 0; V=0.
- MUL: C=V=1 when the upper WIDTH bits of the full product are non-zero, else 0.
- result/flags/out_valid remain stable while out_valid && !out_ready.
- Reset (any state, including mid-MUL): state IDLE, result 0, flags 0, out_valid 0, multiplier aborted with no stale output.

## Timing
- Non-MUL latency: out_valid high 1 cycle after the accept edge.
- MUL latency: out_valid high WIDTH+1 cycles after the accept edge (one shift-add per BUSY cycle).
- Output handshake completes on the edge where out_valid && out_ready. out_valid drops the next cycle and in_ready rises that same cycle.
- Throughput: one non-MUL op per 2 cycles; no overlap of accept and pending result.
- in_ready is 0 while rst is high and 1 in the first cycle after rst is released.

## Configuration
- ALU_MUL_EN defined: opcode 7 uses the iterative multiplier as above.
- ALU_MUL_EN undefined: multiplier not instantiated. Opcode 7 completes like a single-cycle op with result 0 and flags {0,1,0,0}; BUSY is unreachable.

## Structure
- alu_pkg: alu_op_t enum (ALU_ADD..ALU_MUL), state_t enum (IDLE, BUSY, DONE), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module alu_mul_seq: WIDTH-parametrised shift-add multiplier with start, rst, busy/done, and a 2*WIDTH product output. Instantiated only under ALU_MUL_EN.

## Test plan
- ADD with op2=0x7FFF, op1=0x0001 -> result 0x8000, flags N=1 Z=0 C=0 V=1, out_valid exactly 1 cycle after accept.
- SUB with op2=0x0003, op1=0x0005 -> result 0xFFFE, N=1 C=1 V=0. SUB with op2=0x8000, op1=0x0001 -> result 0x7FFF, V=1.
- SHL with op2=0x8001, op1=1 -> result 0x0002, C=1. SHR with op2=0x0001, op1=0 -> result 0x0001, C=0.
- MUL with 0x0100*0x0100 -> result 0x0000, Z=1 C=1 V=1, out_valid 17 cycles after accept. MUL with 0x0003*0x0005 -> result 0x000F, C=V=0.
- Backpressure: hold out_ready low for 5 cycles after out_valid -> result and flags stable, in_ready 0, new in_valid ignored. Raise out_ready -> in_ready 1 on the next cycle.
- Assert rst 8 cycles into a MUL -> out_valid 0, result 0, flags 0, no late out_valid; in_ready 1 in the first cycle after rst is released.
